// File: rtl/noise_gate_ahr.sv
// Per-sample noise gate: hysteresis thresholds with an attack/open/hold/release gain envelope.
// Build option: define GATE_SOFT_RAMP_EN for gain ramps; undefined gives a hard 0/unity gate.
module noise_gate_ahr #(
    parameter int DATA_W   = 16,
    parameter int GAIN_W   = 8,
    parameter int HOLD_W   = 16,
    parameter int ATK_STEP = 64,
    parameter int REL_STEP = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_enable,
    input  logic [2:0]               i_level,
    input  logic [HOLD_W-1:0]        i_hold_len,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_valid,
    output logic [2:0]               o_state,
    output logic                     o_gate_open
);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } gate_state_e;

    localparam int THR_SHL = (DATA_W > 16) ? (DATA_W - 16) : 0;
    localparam int THR_SHR = (DATA_W < 16) ? (16 - DATA_W) : 0;

    localparam logic [GAIN_W:0]              GAIN_UNITY    = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0]              GAIN_ZERO     = {(GAIN_W+1){1'b0}};
    localparam logic [HOLD_W-1:0]            CNT_ZERO      = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0]            CNT_ONE       = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic signed [DATA_W-1:0]     DATA_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]            DATA_MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    // Open thresholds are tabulated for 16-bit samples and rescaled to DATA_W.
    function automatic logic [DATA_W-1:0] open_threshold(input logic [2:0] level);
        logic [15:0]        base;
        logic [DATA_W+15:0] wide;
        case (level)
            3'd0:    base = 16'd100;
            3'd1:    base = 16'd300;
            3'd2:    base = 16'd600;
            3'd3:    base = 16'd1200;
            3'd4:    base = 16'd2400;
            3'd5:    base = 16'd4000;
            3'd6:    base = 16'd8000;
            default: base = 16'd15000;
        endcase
        wide = {{DATA_W{1'b0}}, base};
        wide = (wide << THR_SHL) >> THR_SHR;
        return wide[DATA_W-1:0];
    endfunction

    gate_state_e                      state_r, state_nxt_s;
    logic [GAIN_W:0]                  gain_r, gain_nxt_s;
    logic [HOLD_W-1:0]                cnt_r, cnt_nxt_s;
    logic signed [DATA_W-1:0]         data_r;
    logic                             valid_r;
    logic                             gate_open_r;

    logic [DATA_W-1:0]                mag_s;
    logic [DATA_W-1:0]                open_thr_s;
    logic [DATA_W-1:0]                close_thr_s;
    logic                             loud_s;
    logic                             quiet_s;
    logic signed [DATA_W+GAIN_W+1:0]  data_ext_s;
    logic signed [DATA_W+GAIN_W+1:0]  gain_ext_s;
    logic signed [DATA_W+GAIN_W+1:0]  prod_s;
    logic signed [DATA_W-1:0]         scaled_s;

    // Sample magnitude, threshold comparison and gain-scaled sample.
    always_comb begin
        if (i_data == DATA_MOST_NEG) begin
            mag_s = DATA_MAX_POS;
        end else if (i_data[DATA_W-1]) begin
            mag_s = $unsigned(-i_data);
        end else begin
            mag_s = $unsigned(i_data);
        end
        open_thr_s  = open_threshold(i_level);
        close_thr_s = open_thr_s >> 1;
        loud_s      = (mag_s >= open_thr_s);
        quiet_s     = (mag_s < close_thr_s);
        data_ext_s  = {{(GAIN_W+2){i_data[DATA_W-1]}}, i_data};
        gain_ext_s  = {{(DATA_W+1){1'b0}}, gain_r};
        prod_s      = data_ext_s * gain_ext_s;
        scaled_s    = DATA_W'(prod_s >>> GAIN_W);
    end

`ifdef GATE_SOFT_RAMP_EN
    localparam logic [GAIN_W+1:0] ATK_INC = (GAIN_W+2)'(ATK_STEP);
    localparam logic [GAIN_W:0]   REL_DEC = (GAIN_W+1)'(REL_STEP);

    logic [GAIN_W+1:0] gain_sum_s;
    logic [GAIN_W:0]   gain_up_s;
    logic [GAIN_W:0]   gain_dn_s;

    // Saturating attack step and floored release step of the current gain.
    always_comb begin
        gain_sum_s = {1'b0, gain_r} + ATK_INC;
        if (gain_sum_s >= {1'b0, GAIN_UNITY}) begin
            gain_up_s = GAIN_UNITY;
        end else begin
            gain_up_s = gain_sum_s[GAIN_W:0];
        end
        if (gain_r > REL_DEC) begin
            gain_dn_s = gain_r - REL_DEC;
        end else begin
            gain_dn_s = GAIN_ZERO;
        end
    end
`endif

    // Envelope next-state; only committed on strobe cycles.
    always_comb begin
        state_nxt_s = state_r;
        gain_nxt_s  = gain_r;
        cnt_nxt_s   = cnt_r;
        if (!i_enable) begin
            state_nxt_s = ST_CLOSED;
            gain_nxt_s  = GAIN_ZERO;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_CLOSED: begin
                    gain_nxt_s = GAIN_ZERO;
                    if (loud_s) begin
`ifdef GATE_SOFT_RAMP_EN
                        // The first attack step is applied on the opening sample itself.
                        gain_nxt_s = gain_up_s;
                        if (gain_up_s == GAIN_UNITY) begin
                            state_nxt_s = ST_OPEN;
                        end else begin
                            state_nxt_s = ST_ATTACK;
                        end
`else
                        gain_nxt_s  = GAIN_UNITY;
                        state_nxt_s = ST_OPEN;
`endif
                    end else begin
                        state_nxt_s = ST_CLOSED;
                    end
                end
`ifdef GATE_SOFT_RAMP_EN
                ST_ATTACK: begin
                    gain_nxt_s = gain_up_s;
                    if (gain_up_s == GAIN_UNITY) begin
                        state_nxt_s = ST_OPEN;
                    end else begin
                        state_nxt_s = ST_ATTACK;
                    end
                end
`endif
                ST_OPEN: begin
                    gain_nxt_s = GAIN_UNITY;
                    if (quiet_s) begin
                        if (i_hold_len == CNT_ZERO) begin
`ifdef GATE_SOFT_RAMP_EN
                            state_nxt_s = ST_RELEASE;
`else
                            state_nxt_s = ST_CLOSED;
                            gain_nxt_s  = GAIN_ZERO;
`endif
                        end else begin
                            cnt_nxt_s   = i_hold_len;
                            state_nxt_s = ST_HOLD;
                        end
                    end else begin
                        state_nxt_s = ST_OPEN;
                    end
                end
                ST_HOLD: begin
                    gain_nxt_s = GAIN_UNITY;
                    if (loud_s) begin
                        state_nxt_s = ST_OPEN;
                    end else if (cnt_r == CNT_ONE) begin
`ifdef GATE_SOFT_RAMP_EN
                        state_nxt_s = ST_RELEASE;
`else
                        state_nxt_s = ST_CLOSED;
                        gain_nxt_s  = GAIN_ZERO;
`endif
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
`ifdef GATE_SOFT_RAMP_EN
                ST_RELEASE: begin
                    // A retrigger keeps the current gain and resumes the attack from it.
                    if (loud_s) begin
                        state_nxt_s = ST_ATTACK;
                    end else begin
                        gain_nxt_s = gain_dn_s;
                        if (gain_dn_s == GAIN_ZERO) begin
                            state_nxt_s = ST_CLOSED;
                        end else begin
                            state_nxt_s = ST_RELEASE;
                        end
                    end
                end
`endif
                default: begin
                    state_nxt_s = ST_CLOSED;
                    gain_nxt_s  = GAIN_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Registered FSM, gain, hold counter and output sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_CLOSED;
            gain_r      <= GAIN_ZERO;
            cnt_r       <= CNT_ZERO;
            data_r      <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
            gate_open_r <= 1'b0;
        end else if (i_valid) begin
            state_r     <= state_nxt_s;
            gain_r      <= gain_nxt_s;
            cnt_r       <= cnt_nxt_s;
            valid_r     <= 1'b1;
            gate_open_r <= (state_nxt_s == ST_ATTACK) || (state_nxt_s == ST_OPEN) ||
                           (state_nxt_s == ST_HOLD);
            if (i_enable) begin
                data_r <= scaled_s;
            end else begin
                data_r <= i_data;
            end
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_state     = state_r;
    assign o_gate_open = gate_open_r;

endmodule

// File: tb/tb_noise_gate_ahr.sv
// Self-checking bench for noise_gate_ahr: directed envelope scenarios plus randomized
// stimulus compared against a sample-level behavioural model.
module tb_noise_gate_ahr;

    localparam int DATA_W   = 16;
    localparam int GAIN_W   = 8;
    localparam int HOLD_W   = 16;
    localparam int ATK_STEP = 64;
    localparam int REL_STEP = 16;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     i_valid;
    logic                     i_enable;
    logic [2:0]               i_level;
    logic [HOLD_W-1:0]        i_hold_len;
    logic signed [DATA_W-1:0] i_data;
    logic signed [DATA_W-1:0] o_data;
    logic                     o_valid;
    logic [2:0]               o_state;
    logic                     o_gate_open;

    noise_gate_ahr #(
        .DATA_W   (DATA_W),
        .GAIN_W   (GAIN_W),
        .HOLD_W   (HOLD_W),
        .ATK_STEP (ATK_STEP),
        .REL_STEP (REL_STEP)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_enable    (i_enable),
        .i_level     (i_level),
        .i_hold_len  (i_hold_len),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_state     (o_state),
        .o_gate_open (o_gate_open)
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: 0 closed, 1 attack, 2 open, 3 hold, 4 release
    int m_st  = 0;
    int m_g   = 0;
    int m_cnt = 0;
    int m_out = 0;
    int open_tbl [8] = '{100, 300, 600, 1200, 2400, 4000, 8000, 15000};

    task automatic check_eq(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic model_sample(input bit en, input int lvl, input int hold, input int x);
        int mag, open_t, close_t, unity;
        unity = 1 << GAIN_W;
        if (!en) begin
            m_out = x; m_st = 0; m_g = 0; m_cnt = 0;
        end else begin
            m_out   = (x * m_g) >>> GAIN_W;
            mag     = (x < 0) ? -x : x;
            if (mag > 32767) mag = 32767;
            open_t  = open_tbl[lvl];
            close_t = open_t / 2;
            case (m_st)
                0: if (mag >= open_t) begin
`ifdef GATE_SOFT_RAMP_EN
                    m_g  = (ATK_STEP < unity) ? ATK_STEP : unity;
                    m_st = (m_g == unity) ? 2 : 1;
`else
                    m_g  = unity;
                    m_st = 2;
`endif
                end
                1: begin
                    m_g = m_g + ATK_STEP;
                    if (m_g >= unity) begin m_g = unity; m_st = 2; end
                end
                2: if (mag < close_t) begin
                    if (hold == 0) begin
`ifdef GATE_SOFT_RAMP_EN
                        m_st = 4;
`else
                        m_st = 0; m_g = 0;
`endif
                    end else begin
                        m_cnt = hold; m_st = 3;
                    end
                end
                3: if (mag >= open_t) m_st = 2;
                   else if (m_cnt == 1) begin
`ifdef GATE_SOFT_RAMP_EN
                       m_st = 4;
`else
                       m_st = 0; m_g = 0;
`endif
                   end else m_cnt = m_cnt - 1;
                4: if (mag >= open_t) m_st = 1;
                   else begin
                       m_g = m_g - REL_STEP;
                       if (m_g <= 0) begin m_g = 0; m_st = 0; end
                   end
                default: ;
            endcase
        end
    endtask

    // One clock: drive at negedge, update model, check outputs just after the edge.
    task automatic step(input bit rst, input bit v, input bit en, input int lvl, input int hold, input int x);
        i_rst      = rst;
        i_valid    = v;
        i_enable   = en;
        i_level    = lvl[2:0];
        i_hold_len = hold[HOLD_W-1:0];
        i_data     = x[DATA_W-1:0];
        @(posedge i_clk);
        #1;
        if (rst) begin
            m_st = 0; m_g = 0; m_cnt = 0; m_out = 0;
        end else if (v) begin
            model_sample(en, lvl, hold, x);
        end
        check_eq("o_valid", int'(o_valid), (v && !rst) ? 1 : 0);
        check_eq("o_data", int'(o_data), m_out);
        check_eq("o_state", int'(o_state), m_st);
        check_eq("o_gate_open", int'(o_gate_open), (m_st >= 1 && m_st <= 3) ? 1 : 0);
        @(negedge i_clk);
    endtask

    function automatic int gen_sample(input int mode, input int lvl);
        int open_t, mag;
        open_t = open_tbl[lvl];
        case (mode)
            0:       mag = $urandom_range(0, open_t / 2 - 1);
            1:       mag = $urandom_range(open_t / 2, open_t - 1);
            2:       mag = $urandom_range(open_t, 32767);
            default: return -32768;
        endcase
        return ($urandom_range(0, 1) == 1) ? -mag : mag;
    endfunction

    int atk_out [5] = '{0, 250, 500, 750, 1000};
    int atk_st  [5] = '{1, 1, 1, 2, 2};

    initial begin
        bit en;
        int lvl, hold, mode, x;
        bit v, rst;

        i_rst = 1'b1; i_valid = 1'b0; i_enable = 1'b1;
        i_level = 3'd0; i_hold_len = 16'd0; i_data = 16'sd0;
        @(negedge i_clk);
        step(1'b1, 1'b0, 1'b1, 0, 0, 0);

        // Reset with a strobe in the same cycle: strobe dropped
        step(1'b1, 1'b1, 1'b1, 0, 0, 1234);
        check_eq("rst_data", int'(o_data), 0);
        check_eq("rst_state", int'(o_state), 0);

        // Bypass passes the most-negative sample through untouched
        step(1'b0, 1'b1, 1'b0, 0, 0, -32768);
        check_eq("byp_data", int'(o_data), -32768);
        check_eq("byp_valid", int'(o_valid), 1);

        // Attack from closed at level 2
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 2, 3, 1000);
`ifdef GATE_SOFT_RAMP_EN
            check_eq("atk_data", int'(o_data), atk_out[i]);
            check_eq("atk_state", int'(o_state), atk_st[i]);
`endif
        end

        // Hysteresis: between close and open keeps the gate open
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 2, 3, 400);
            check_eq("hyst_data", int'(o_data), 400);
            check_eq("hyst_state", int'(o_state), 2);
        end

        // Hold of 3 samples followed by the release fade
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 2, 3, 100);
`ifdef GATE_SOFT_RAMP_EN
            if (i <= 5)  check_eq("hold_data", int'(o_data), 100);
            if (i == 6)  check_eq("rel_data1", int'(o_data), 93);
            if (i == 7)  check_eq("rel_data2", int'(o_data), 87);
            if (i == 19) check_eq("rel_state", int'(o_state), 4);
            if (i == 20) check_eq("rel_closed", int'(o_state), 0);
`endif
        end

        // Retrigger from release at half gain
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 2, 0, 1000);
        step(1'b0, 1'b1, 1'b1, 2, 0, 100);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 2, 0, 100);
        step(1'b0, 1'b1, 1'b1, 2, 0, 2000);
`ifdef GATE_SOFT_RAMP_EN
        check_eq("retrig_data", int'(o_data), 1000);
        check_eq("retrig_state", int'(o_state), 1);
`endif
        step(1'b0, 1'b1, 1'b1, 2, 0, 2000);
`ifdef GATE_SOFT_RAMP_EN
        check_eq("retrig_data2", int'(o_data), 1000);
`endif
        step(1'b0, 1'b1, 1'b1, 2, 0, 2000);
`ifdef GATE_SOFT_RAMP_EN
        check_eq("retrig_g192", int'(o_data), 1500);
`endif

        // Saturated magnitude opens level 7, then reset lands mid-attack
        step(1'b0, 1'b1, 1'b0, 7, 0, 0);
        step(1'b0, 1'b1, 1'b1, 7, 0, -32768);
        step(1'b0, 1'b1, 1'b1, 7, 0, -32768);
`ifdef GATE_SOFT_RAMP_EN
        check_eq("sat_data", int'(o_data), -8192);
        check_eq("sat_state", int'(o_state), 1);
`endif
        step(1'b1, 1'b1, 1'b1, 7, 0, -32768);
        check_eq("midrst_data", int'(o_data), 0);
        check_eq("midrst_gate", int'(o_gate_open), 0);
        step(1'b0, 1'b1, 1'b1, 7, 0, -32768);

        // Randomized traffic: gaps, back-to-back strobes, bypass toggles, resets
        en = 1'b1; lvl = 2; hold = 2; mode = 0;
        for (int n = 0; n < 4000; n++) begin
            v   = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 599) == 0);
            if (n % 150 == 0) lvl = $urandom_range(0, 7);
            if (n % 10 == 0)  mode = $urandom_range(0, 3);
            if (v && $urandom_range(0, 49) == 0) en = !en;
            if (v) hold = $urandom_range(0, 5);
            x = gen_sample(mode, lvl);
            step(rst, v, en, lvl, hold, x);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/noise_gate_ahr.md
# noise_gate_ahr

Parametrised noise gate with hysteresis and an attack/hold/release envelope. It replaces hard per-sample muting with a gain state machine that opens on loud input, holds for a programmable number of samples, and fades out. It sits in the per-sample effect chain: input samples qualified by a strobe, one registered output sample per strobe.

## Interface
- DATA_W, 16: sample width, signed two's complement (≥8).
- GAIN_W, 8: gain fraction bits; unity gain = 2^GAIN_W.
- HOLD_W, 16: hold counter width.
- ATK_STEP, 64: gain increment per sample in ATTACK.
- REL_STEP, 16: gain decrement per sample in RELEASE.

- i_clk  in  1  audio bit clock; all state changes on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  new-sample strobe, one cycle wide.
- i_enable  in  1  1 = gate active, 0 = bypass.
- i_level  in  3  threshold select 0–7.
- i_hold_len  in  HOLD_W  hold time in samples.
- i_data  in  DATA_W  signed input sample.
- o_data  out  DATA_W  signed gated sample.
- o_valid  out  1  one-cycle strobe, output updated.
- o_state  out  3  FSM state: CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4.
- o_gate_open  out  1  1 in ATTACK, OPEN, HOLD.

## Operation
- Magnitude: abs(i_data); most-negative value saturates to 2^(DATA_W-1)-1.
- Open threshold at DATA_W=16, by level: 100, 300, 600, 1200, 2400, 4000, 8000, 15000. DATA_W>16: shift left by DATA_W-16. DATA_W<16: shift right by 16-DATA_W. Close threshold = open >> 1.
- Gain register g: GAIN_W+1 bits, unsigned, range 0..2^GAIN_W.
- Output: o_data = (i_data × g) >>> GAIN_W, signed, arithmetic shift (floor). g = unity returns i_data exactly. g is the value held before this sample's update.
- FSM transitions are evaluated only on cycles with i_valid:
  - CLOSED: g=0. If abs ≥ open, go to ATTACK.
  - ATTACK: g += ATK_STEP, saturating at unity. On reaching unity, go to OPEN. Input level is ignored.
  - OPEN: g = unity. If abs < close: load counter with i_hold_len and go to HOLD; if i_hold_len = 0, go straight to RELEASE.
  - HOLD: g = unity. If abs ≥ open, go to OPEN. Otherwise, if counter = 1, go to RELEASE; else decrement the counter.
  - RELEASE: if abs ≥ open, go to ATTACK and do not update g this sample. Otherwise g -= REL_STEP, floored at 0; on reaching 0, go to CLOSED.
- Bypass (i_enable=0): o_data = i_data on each valid; FSM is forced to CLOSED, g=0, counter=0. Re-enabling starts from CLOSED.
- i_level and i_hold_len are sampled on each valid. Changing them mid-hold does not reload the counter.

## Timing
- Latency: o_data and o_valid are registered one cycle after the i_valid cycle. o_valid is high exactly one cycle per input strobe.
- o_data holds its value between strobes.
- Back-to-back i_valid on consecutive cycles is supported; each strobe produces one output.
- o_state and o_gate_open reflect the registered FSM state, updated on the same edge as o_data.
- Reset (any cycle, including mid-ramp or mid-hold): o_data=0, o_valid=0, state CLOSED, o_gate_open=0, g=0, counter=0. An i_valid in the reset cycle is dropped.

## Configuration
- GATE_SOFT_RAMP_EN defined: full ATTACK/RELEASE ramp behaviour as described above.
- GATE_SOFT_RAMP_EN undefined: ATTACK and RELEASE are never entered.
  - CLOSED goes directly to OPEN with g=unity.
  - HOLD expiry, or i_hold_len=0 in OPEN, goes directly to CLOSED with g=0.
  - g is only ever 0 or unity.
  - ATK_STEP and REL_STEP are unused.

## Test plan
All scenarios use defaults with GATE_SOFT_RAMP_EN defined.
- Reset: assert i_rst with i_valid=1 → next cycle o_data=0, o_valid=0, o_state=0.
- Bypass: i_enable=0, i_data=-32768 → o_data=-32768, o_valid=1 one cycle later, o_state=0.
- Attack: level 2, five valids of 1000 from CLOSED → outputs 0, 250, 500, 750, 1000; o_state sequence 1, 1, 1, 2, 2.
- Hysteresis and hold: OPEN, hold_len=3.
  - Samples of 400 → output 400, state remains OPEN.
  - Then samples of 100 → five outputs of 100, then 93, 87 (g=240, 224); CLOSED after 16 release samples.
- Retrigger: in RELEASE with g=128, sample 2000 → output 1000, state ATTACK; next sample 2000 → output 1000, g becomes 192.
- Saturation and reset mid-ramp: level 7, i_data=-32768 opens the gate from CLOSED; assert i_rst during ATTACK → all outputs return to reset values next cycle.
